// File: rtl/fetch_npc.sv
// fetch_npc: F-stage program counter, IF/ID pipeline register and next-PC
// selection for the five-stage MIPS pipeline. Redirects come from the
// D-stage branch decision, j/jal and jr/jalr, with priority jr > j > branch.
// Optional feature macro: FETCH_DELAY_SLOT_EN
//   defined   -> the instruction behind a taken redirect executes (delay slot)
//   undefined -> that instruction is squashed into a bubble
module fetch_npc #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_take,
  input  logic [15:0] br_imm16,
  input  logic        j_en,
  input  logic [25:0] j_index26,
  input  logic        jr_en,
  input  logic [31:0] jr_target,
  output logic [31:0] pc_f,
  input  logic [31:0] instr_f,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc8_d,
  output logic        valid_d,
  output logic        pc_err
);

  logic [31:0] pc_f_q, pc_f_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic        pc_err_q, pc_err_d;

  logic [31:0] pc_d_plus4;
  logic [31:0] br_offset;
  logic [31:0] br_dest;
  logic [31:0] j_dest;
  logic [31:0] jr_dest;
  logic [31:0] redirect_dest;
  logic        redirect;

  // Redirect targets from the D-stage PC, and the single winning destination
  always_comb begin
    pc_d_plus4 = ifid_pc_q + 32'd4;
    br_offset  = {{14{br_imm16[15]}}, br_imm16, 2'b00};
    br_dest    = pc_d_plus4 + br_offset;
    j_dest     = {pc_d_plus4[31:28], j_index26, 2'b00};
    jr_dest    = {jr_target[31:2], 2'b00};
    redirect   = (jr_en | j_en | br_take) & ifid_valid_q & ~stall;
    if (jr_en) begin
      redirect_dest = jr_dest;
    end else if (j_en) begin
      redirect_dest = j_dest;
    end else begin
      redirect_dest = br_dest;
    end
  end

  // Next fetch PC, next IF/ID contents and the sticky misaligned-jr flag
  always_comb begin
    pc_f_d       = pc_f_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_valid_d = ifid_valid_q;
    pc_err_d     = pc_err_q |
                   (jr_en & ifid_valid_q & ~stall & (jr_target[1:0] != 2'b00));
    if (!stall) begin
      pc_f_d       = redirect ? redirect_dest : (pc_f_q + 32'd4);
      ifid_instr_d = instr_f;
      ifid_pc_d    = pc_f_q;
      ifid_valid_d = 1'b1;
`ifdef FETCH_DELAY_SLOT_EN
`else
      if (redirect) begin
        ifid_instr_d = 32'd0;
        ifid_valid_d = 1'b0;
      end
`endif
    end
  end

  // State registers, cleared asynchronously to the reset PC
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_f_q       <= PC_RESET;
      ifid_instr_q <= 32'd0;
      ifid_pc_q    <= PC_RESET;
      ifid_valid_q <= 1'b0;
      pc_err_q     <= 1'b0;
    end else begin
      pc_f_q       <= pc_f_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_valid_q <= ifid_valid_d;
      pc_err_q     <= pc_err_d;
    end
  end

  assign pc_f    = pc_f_q;
  assign instr_d = ifid_instr_q;
  assign pc_d    = ifid_pc_q;
  assign pc8_d   = ifid_pc_q + 32'd8;
  assign valid_d = ifid_valid_q;
  assign pc_err  = pc_err_q;

endmodule

// File: tb/tb_fetch_npc.sv
// Directed bench for fetch_npc. Instruction memory is a combinational
// pattern {addr[15:0], ~addr[15:0]} so each fetched word identifies its PC.
module tb_fetch_npc;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        brTake;
  logic [15:0] brImm16;
  logic        jEn;
  logic [25:0] jIndex26;
  logic        jrEn;
  logic [31:0] jrTarget;
  logic [31:0] pcF;
  logic [31:0] instrF;
  logic [31:0] instrD;
  logic [31:0] pcD;
  logic [31:0] pc8D;
  logic        validD;
  logic        pcErr;

  int checks = 0;
  int errors = 0;

  fetch_npc dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .br_take   (brTake),
    .br_imm16  (brImm16),
    .j_en      (jEn),
    .j_index26 (jIndex26),
    .jr_en     (jrEn),
    .jr_target (jrTarget),
    .pc_f      (pcF),
    .instr_f   (instrF),
    .instr_d   (instrD),
    .pc_d      (pcD),
    .pc8_d     (pc8D),
    .valid_d   (validD),
    .pc_err    (pcErr)
  );

  function automatic logic [31:0] im(input logic [31:0] addr);
    return {addr[15:0], ~addr[15:0]};
  endfunction

  assign instrF = im(pcF);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic st, input logic br, input logic [15:0] imm,
                               input logic j, input logic [25:0] idx,
                               input logic jr, input logic [31:0] tgt);
    stall    = st;
    brTake   = br;
    brImm16  = imm;
    jEn      = j;
    jIndex26 = idx;
    jrEn     = jr;
    jrTarget = tgt;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
    #2;
    checkOutput("rst_pc_f",    pcF,            32'h0000_3000);
    checkOutput("rst_instr_d", instrD,         32'h0);
    checkOutput("rst_pc_d",    pcD,            32'h0000_3000);
    checkOutput("rst_pc8_d",   pc8D,           32'h0000_3008);
    checkOutput("rst_valid_d", {31'h0, validD}, 32'h0);
    checkOutput("rst_pc_err",  {31'h0, pcErr},  32'h0);

    // a branch request during the post-reset bubble must be ignored
    applyStimulus(1'b0, 1'b1, 16'h0010, 1'b0, 26'h0, 1'b0, 32'h0);
    #1 reset = 1'b0;
    step();
    checkOutput("e1_pc_f",    pcF,             32'h0000_3004);
    checkOutput("e1_instr_d", instrD,          im(32'h0000_3000));
    checkOutput("e1_valid_d", {31'h0, validD}, 32'h1);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
    step();
    checkOutput("e2_pc_f", pcF, 32'h0000_3008);
    step();
    checkOutput("e3_pc_f",    pcF,    32'h0000_300C);
    checkOutput("e3_instr_d", instrD, im(32'h0000_3008));
    checkOutput("e3_pc_d",    pcD,    32'h0000_3008);
    step();
    step();
    checkOutput("e5_pc_d", pcD, 32'h0000_3010);

    // backward branch: 3010 + 4 - 16 = 3004
    applyStimulus(1'b0, 1'b1, 16'hFFFC, 1'b0, 26'h0, 1'b0, 32'h0);
    checkOutput("br_pc8_d", pc8D, 32'h0000_3018);
    step();
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
    checkOutput("br_pc_f", pcF, 32'h0000_3004);
    checkOutput("br_pc_d", pcD, 32'h0000_3014);
`ifdef FETCH_DELAY_SLOT_EN
    checkOutput("br_instr_d", instrD,          im(32'h0000_3014));
    checkOutput("br_valid_d", {31'h0, validD}, 32'h1);
`else
    checkOutput("br_instr_d", instrD,          32'h0);
    checkOutput("br_valid_d", {31'h0, validD}, 32'h0);
`endif
    step();
    checkOutput("br_tgt_pc_d",    pcD,             32'h0000_3004);
    checkOutput("br_tgt_instr_d", instrD,          im(32'h0000_3004));
    checkOutput("br_tgt_valid_d", {31'h0, validD}, 32'h1);
    for (int i = 0; i < 7; i++) step();
    checkOutput("pre_j_pc_d", pcD, 32'h0000_3020);

    // jump: {0, 26'hC10, 00} = 3040
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 26'h0000C10, 1'b0, 32'h0);
    checkOutput("j_pc8_d", pc8D, 32'h0000_3028);
    step();
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
    checkOutput("j_pc_f", pcF, 32'h0000_3040);
`ifdef FETCH_DELAY_SLOT_EN
    checkOutput("j_valid_d", {31'h0, validD}, 32'h1);
`else
    checkOutput("j_valid_d", {31'h0, validD}, 32'h0);
`endif
    step();
    checkOutput("pre_st_pc_d", pcD, 32'h0000_3040);

    // stall two cycles with a pending branch to 3040 + 4 + 16 = 3054
    applyStimulus(1'b1, 1'b1, 16'h0004, 1'b0, 26'h0, 1'b0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      step();
      checkOutput("st_pc_f",    pcF,             32'h0000_3044);
      checkOutput("st_pc_d",    pcD,             32'h0000_3040);
      checkOutput("st_instr_d", instrD,          im(32'h0000_3040));
      checkOutput("st_valid_d", {31'h0, validD}, 32'h1);
    end
    applyStimulus(1'b0, 1'b1, 16'h0004, 1'b0, 26'h0, 1'b0, 32'h0);
    step();
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
    checkOutput("unst_pc_f", pcF, 32'h0000_3054);
    checkOutput("unst_pc_d", pcD, 32'h0000_3044);
    step();
    checkOutput("pre_jr_pc_f", pcF, 32'h0000_3058);

    // jr to misaligned 3031 together with a branch: jr wins, error latches
    applyStimulus(1'b0, 1'b1, 16'h0100, 1'b0, 26'h0, 1'b1, 32'h0000_3031);
    checkOutput("pre_jr_pc_err", {31'h0, pcErr}, 32'h0);
    step();
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
    checkOutput("jr_pc_f",   pcF,             32'h0000_3030);
    checkOutput("jr_pc_err", {31'h0, pcErr},  32'h1);
    step();
    checkOutput("jr_sticky_pc_f",   pcF,            32'h0000_3034);
    checkOutput("jr_sticky_pc_err", {31'h0, pcErr}, 32'h1);

    // jr to the top word, then sequential fetch wraps to zero
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'hFFFF_FFFC);
    step();
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
    checkOutput("top_pc_f", pcF, 32'hFFFF_FFFC);
    step();
    checkOutput("wrap_pc_f",   pcF,            32'h0);
    checkOutput("wrap_pc_d",   pcD,            32'hFFFF_FFFC);
    checkOutput("wrap_pc8_d",  pc8D,           32'h0000_0004);
    checkOutput("wrap_pc_err", {31'h0, pcErr}, 32'h1);

    // asynchronous reset in the middle of a cycle
    #2 reset = 1'b1;
    #1;
    checkOutput("arst_pc_f",    pcF,             32'h0000_3000);
    checkOutput("arst_instr_d", instrD,          32'h0);
    checkOutput("arst_valid_d", {31'h0, validD}, 32'h0);
    checkOutput("arst_pc_err",  {31'h0, pcErr},  32'h0);
    @(negedge clk);
    reset = 1'b0;
    step();
    checkOutput("post_arst_pc_f", pcF, 32'h0000_3004);
    checkOutput("post_arst_pc_d", pcD, 32'h0000_3000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
